// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 frame assembler: FSM encoding, frame geometry
// and a byte-extraction helper used by the assembler and the checksum unit.
package dht11_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_CHECK   = 2'd2,
        ST_PUBLISH = 2'd3
    } state_e;

    localparam int DHT11_FRAME_BITS = 40;
    localparam int DHT11_CLK_HZ     = 50_000_000;

    // Byte positions inside the frame; the first received bit lands in bit 39.
    localparam int HUM_INT_LSB  = 32;
    localparam int HUM_DEC_LSB  = 24;
    localparam int TEMP_INT_LSB = 16;
    localparam int TEMP_DEC_LSB = 8;
    localparam int CSUM_LSB     = 0;

    function automatic logic [7:0] frame_byte(input logic [DHT11_FRAME_BITS-1:0] f,
                                              input int lsb);
        return 8'(f >> lsb);
    endfunction

endpackage

// File: rtl/dht11_frame_assembler_if.sv
// Receiver-side strobes and published sensor data of the DHT11 frame assembler.
// The master modport is the upstream receiver/consumer side, slave is the assembler.
interface dht11_frame_assembler_if;

    logic       frame_start;
    logic       bit_in;
    logic       bit_valid;
    logic       frame_abort;
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
    logic       data_valid;
    logic       chk_err;
    logic       busy;
    logic [7:0] err_count;

    modport master (
        output frame_start, bit_in, bit_valid, frame_abort,
        input  hum_int, hum_dec, temp_int, temp_dec,
        input  data_valid, chk_err, busy, err_count
    );

    modport slave (
        input  frame_start, bit_in, bit_valid, frame_abort,
        output hum_int, hum_dec, temp_int, temp_dec,
        output data_valid, chk_err, busy, err_count
    );

endinterface

// File: rtl/dht11_checksum.sv
// Combinational DHT11 checksum: the four data bytes summed mod 256 must equal
// the trailing checksum byte.
module dht11_checksum
    import dht11_pkg::*;
(
    input  logic [DHT11_FRAME_BITS-1:0] frame_i,
    output logic                        ok_o,
    output logic [7:0]                  sum_o
);

    logic [7:0] data_byte [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign data_byte[gi] = frame_byte(frame_i, HUM_INT_LSB - 8 * gi);
        end
    endgenerate

    assign sum_o = data_byte[0] + data_byte[1] + data_byte[2] + data_byte[3];
    assign ok_o  = (sum_o == frame_byte(frame_i, CSUM_LSB));

endmodule

// File: rtl/dht11_frame_assembler.sv
// Assembles the 40-bit DHT11 frame, checks it and publishes humidity/temperature.
// Optional macro DHT11_ERRCNT_EN enables the saturating error counter on err_count.
module dht11_frame_assembler
    import dht11_pkg::*;
#(
    parameter int FRAME_BITS = DHT11_FRAME_BITS,
    parameter int GAP_CYCLES = 250000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    dht11_frame_assembler_if.slave  bus
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
    logic [7:0]              hum_int_q, hum_int_d;
    logic [7:0]              hum_dec_q, hum_dec_d;
    logic [7:0]              temp_int_q, temp_int_d;
    logic [7:0]              temp_dec_q, temp_dec_d;
    logic                    data_valid_q, data_valid_d;
    logic                    chk_err_q, chk_err_d;
    logic                    err_evt;
    logic                    csum_ok;
    logic [7:0]              csum_unused;
    logic                    last_bit;
    logic                    gap_expired;

    dht11_checksum u_checksum (
        .frame_i (shift_q),
        .ok_o    (csum_ok),
        .sum_o   (csum_unused)
    );

    assign last_bit    = (bit_cnt_q == CNT_W'(FRAME_BITS - 1));
    assign gap_expired = (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Inside COLLECT the priority is abort > restart > bit > gap timeout.
    always_comb begin
        state_d = state_q;
        if (en_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.frame_start) state_d = ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (bus.frame_abort)      state_d = ST_IDLE;
                    else if (bus.frame_start) state_d = ST_COLLECT;
                    else if (bus.bit_valid) begin
                        if (last_bit) state_d = ST_CHECK;
                    end else if (gap_expired) state_d = ST_IDLE;
                end
                ST_CHECK:   state_d = csum_ok ? ST_PUBLISH : ST_IDLE;
                ST_PUBLISH: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        hum_int_d    = hum_int_q;
        hum_dec_d    = hum_dec_q;
        temp_int_d   = temp_int_q;
        temp_dec_d   = temp_dec_q;
        chk_err_d    = chk_err_q;
        data_valid_d = 1'b0;
        err_evt      = 1'b0;
        if (en_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.frame_start) begin
                        shift_d   = '0;
                        bit_cnt_d = '0;
                        gap_cnt_d = '0;
                    end
                end
                ST_COLLECT: begin
                    if (bus.frame_abort) begin
                        err_evt = 1'b1;
                    end else if (bus.frame_start) begin
                        shift_d   = '0;
                        bit_cnt_d = '0;
                        gap_cnt_d = '0;
                    end else if (bus.bit_valid) begin
                        shift_d   = {shift_q[FRAME_BITS-2:0], bus.bit_in};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        gap_cnt_d = '0;
                    end else if (gap_expired) begin
                        err_evt = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (!csum_ok) err_evt = 1'b1;
                end
                ST_PUBLISH: begin
                    hum_int_d    = frame_byte(shift_q, HUM_INT_LSB);
                    hum_dec_d    = frame_byte(shift_q, HUM_DEC_LSB);
                    temp_int_d   = frame_byte(shift_q, TEMP_INT_LSB);
                    temp_dec_d   = frame_byte(shift_q, TEMP_DEC_LSB);
                    data_valid_d = 1'b1;
                    chk_err_d    = 1'b0;
                end
                default: ;
            endcase
        end
        if (err_evt) chk_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            hum_int_q    <= 8'h00;
            hum_dec_q    <= 8'h00;
            temp_int_q   <= 8'h00;
            temp_dec_q   <= 8'h00;
            data_valid_q <= 1'b0;
            chk_err_q    <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            hum_int_q    <= hum_int_d;
            hum_dec_q    <= hum_dec_d;
            temp_int_q   <= temp_int_d;
            temp_dec_q   <= temp_dec_d;
            data_valid_q <= data_valid_d;
            chk_err_q    <= chk_err_d;
        end
    end

`ifdef DHT11_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_evt && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_count = err_cnt_q;
`else
    assign bus.err_count = 8'h00;
`endif

    assign bus.hum_int    = hum_int_q;
    assign bus.hum_dec    = hum_dec_q;
    assign bus.temp_int   = temp_int_q;
    assign bus.temp_dec   = temp_dec_q;
    assign bus.data_valid = data_valid_q;
    assign bus.chk_err    = chk_err_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: doc/dht11_frame_assembler.md
Name: dht11_frame_assembler

Overview:
Sits directly downstream of the DHT11 single-wire receiver and consumes its serial bit stream. It assembles the 40 received bits, MSB first, into a frame and verifies the DHT11 checksum. It then publishes humidity and temperature bytes to the display/UART consumers. It also detects aborted and stalled frames.

Parameters:
FRAME_BITS, 40, bits per DHT11 frame (5 bytes)
GAP_CYCLES, 250000, max clk cycles between consecutive bit_valid pulses inside a frame (5 ms at 50 MHz)

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-low reset
en  input  1  block enable; when low, the FSM holds its state and ignores inputs
frame_start  input  1  1-cycle pulse from the receiver after the DHT11 response phase
bit_in  input  1  decoded data bit; qualified by bit_valid
bit_valid  input  1  1-cycle strobe; one per received bit
frame_abort  input  1  1-cycle pulse; receiver detected a protocol error
hum_int  output  8  humidity integer byte
hum_dec  output  8  humidity decimal byte
temp_int  output  8  temperature integer byte
temp_dec  output  8  temperature decimal byte
data_valid  output  1  1-cycle pulse when new checked data is published
chk_err  output  1  sticky flag: last frame failed checksum, gap check or abort
busy  output  1  high while a frame is in progress
err_count  output  8  saturating error counter (see Optional Feature)

Behaviour:
- Reset values: all data outputs 8'h00; data_valid, chk_err and busy at 0; err_count 0; FSM in IDLE; shift register and counters cleared.
- States and transitions:
  - IDLE: on frame_start, clear the shift register, bit_cnt and gap_cnt, go to COLLECT. bit_valid is ignored in IDLE.
  - COLLECT: on bit_valid, shift bit_in into the LSB (frame[39] = first bit received), bit_cnt+1, gap_cnt reset to 0.
    - When the 40th bit is shifted in, go to CHECK on the next cycle.
    - frame_abort, or gap_cnt reaching GAP_CYCLES-1 without a bit_valid, sets chk_err=1 and returns to IDLE; outputs are not updated.
    - A new frame_start while in COLLECT restarts collection: all counters and the shift register are cleared, and no error is flagged.
  - CHECK: compute sum = frame[39:32]+frame[31:24]+frame[23:16]+frame[15:8], truncated mod 256.
    - Equal to frame[7:0]: go to PUBLISH.
    - Otherwise: chk_err=1, go to IDLE, outputs hold their previous values.
  - PUBLISH: load hum_int=frame[39:32], hum_dec=[31:24], temp_int=[23:16], temp_dec=[15:8]. Pulse data_valid for exactly 1 cycle, clear chk_err, return to IDLE.
- Latency: data_valid asserts 2 cycles after the clk edge that samples the 40th bit_valid.
- busy = (state != IDLE).
- Simultaneous events in COLLECT:
  - frame_abort together with bit_valid: abort wins.
  - frame_start together with frame_abort: abort wins.
- en low: no state, counter or register changes, and the gap timer is frozen. Any pending data_valid pulse still completes its single cycle.
- Reset asserted mid-frame returns every register to its reset value immediately (asynchronous).
- All-zero frame (checksum 0 = 0) is valid and publishes zeros.

Optional Feature:
Macro DHT11_ERRCNT_EN.
- Defined: err_count increments on every chk_err set event (checksum, gap or abort). It saturates at 8'hFF and is cleared only by reset.
- Not defined: err_count is tied to 8'h00 and no counter logic is synthesized. The port remains present so that top-level wiring is unchanged.

Decomposition:
- Package dht11_pkg holds:
  - FSM state encoding (IDLE, COLLECT, CHECK, PUBLISH);
  - the DHT11_FRAME_BITS=40 constant;
  - byte-slice index constants;
  - the default clock frequency (50_000_000).
- One natural sub-module: dht11_checksum. It is purely combinational, takes the 40-bit frame, and outputs ok plus sum[7:0]. It is instantiated in the CHECK path and is reusable by a future transmitter/emulator bench model.

Test Plan:
1. Good frame: frame_start, then bits of 0x37_00_19_00_50 (humidity 55%, temperature 25 °C) at 100-cycle spacing -> data_valid once, hum_int=0x37, temp_int=0x19, chk_err=0, busy low afterwards.
2. Bad checksum: bits 0x37_00_19_00_51 -> no data_valid, chk_err=1, outputs keep the previous values from test 1, err_count=1 (with the macro defined).
3. Gap timeout: frame_start, 20 bits, then silence for GAP_CYCLES cycles -> chk_err=1, busy=0; a following good frame clears chk_err and publishes its data.
4. Abort plus restart:
   - frame_abort at bit 12 -> IDLE with chk_err=1.
   - frame_start at bit 30 of a later frame -> collection restarts, chk_err unchanged, and the next 40 bits publish correctly.
5. Control inputs:
   - en low for 1000 cycles mid-frame -> no timeout, collection resumes and completes.
   - Async reset mid-frame -> all outputs 0 within the same cycle.
6. Saturation (macro defined): 300 bad frames -> err_count=0xFF. Macro undefined -> err_count stays 0.
